pipelined_decoder: RTL and testbench



---
 rtl/pipelined_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_pipelined_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_decoder.sv
// pipelined_decoder: RV32I main decoder followed by an IF/ID-to-EX pipeline
// register with a valid/ready handshake, load-use bubble insertion and flush.
//
// Ports
//   clk_i, rst_i                 clock (rising edge), synchronous active-high reset
//   in_valid_i / in_ready_o      upstream handshake (instr_i, pc_i)
//   flush_i                      kill held instruction, refuse input this cycle
//   out_valid_o / out_ready_i    downstream handshake
//   out_instr_o, out_pc_o        registered instruction word and PC
//   rs1_o, rs2_o, rd_o           register fields of the held instruction
//   ALUSrc_o .. MemtoReg_o       datapath controls of the held instruction
//   ALUOp_o                      00 add, 01 branch compare, 10 R-type, 11 I-ALU
//   illegal_o                    unrecognised or disabled opcode
//   stall_o                      load-use stall (combinational)
module pipelined_decoder #(
  parameter bit ENABLE_JUMP  = 1'b1,
  parameter bit HAZARD_CHECK = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic        ALUSrc_o,
  output logic        RegWrite_o,
  output logic        Branch_o,
  output logic        Jump_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        MemtoReg_o,
  output logic [1:0]  ALUOp_o,
  output logic        illegal_o,
  output logic        stall_o
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef struct packed {
    logic       alu_src;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Decode of the incoming word
  logic [6:0] opcode;
  ctrl_t      dec_ctrl;
  logic       uses_rs1;
  logic       uses_rs2;

  assign opcode = instr_i[6:0];

  always_comb begin
    dec_ctrl = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OpR: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b10;
        uses_rs1           = 1'b1;
        uses_rs2           = 1'b1;
      end
      OpIAlu: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 2'b11;
        uses_rs1           = 1'b1;
      end
      OpLoad: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        uses_rs1            = 1'b1;
      end
      OpStore: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        uses_rs1           = 1'b1;
        uses_rs2           = 1'b1;
      end
      OpBranch: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = 2'b01;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
      end
      OpJal: begin
        if (ENABLE_JUMP) begin
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.jump      = 1'b1;
        end else begin
          dec_ctrl.illegal = 1'b1;
        end
      end
      OpJalr: begin
        // A disabled jalr is illegal and reads no register, so it cannot stall.
        if (ENABLE_JUMP) begin
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.jump      = 1'b1;
          dec_ctrl.alu_src   = 1'b1;
          uses_rs1           = 1'b1;
        end else begin
          dec_ctrl.illegal = 1'b1;
        end
      end
      OpLui, OpAuipc: begin
        if (ENABLE_JUMP) begin
          dec_ctrl.reg_write = 1'b1;
          dec_ctrl.alu_src   = 1'b1;
        end else begin
          dec_ctrl.illegal = 1'b1;
        end
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  // Pipeline register state
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  ctrl_t       ctrl_q, ctrl_d;

  // Load-use hazard: a held load whose destination feeds the incoming word
  logic hazard;
  logic rs1_match;
  logic rs2_match;
  logic accept;

  assign rs1_match = uses_rs1 && (instr_i[19:15] == instr_q[11:7]);
  assign rs2_match = uses_rs2 && (instr_i[24:20] == instr_q[11:7]);
  assign hazard    = HAZARD_CHECK && valid_q && ctrl_q.mem_read && (instr_q[11:7] != 5'd0) &&
                     in_valid_i && (rs1_match || rs2_match);

  // Combinational path from flush_i/out_ready_i to in_ready_o is intentional.
  assign in_ready_o = !flush_i && !hazard && (!valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
      ctrl_d  = dec_ctrl;
    end else if (out_ready_i) begin
      // Held word consumed (or hazard bubble): controls cleared so an
      // invalid slot never carries live controls.
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_instr_o = instr_q;
  assign out_pc_o    = pc_q;
  assign rs1_o       = instr_q[19:15];
  assign rs2_o       = instr_q[24:20];
  assign rd_o        = instr_q[11:7];
  assign ALUSrc_o    = ctrl_q.alu_src;
  assign RegWrite_o  = ctrl_q.reg_write;
  assign Branch_o    = ctrl_q.branch;
  assign Jump_o      = ctrl_q.jump;
  assign MemRead_o   = ctrl_q.mem_read;
  assign MemWrite_o  = ctrl_q.mem_write;
  assign MemtoReg_o  = ctrl_q.mem_to_reg;
  assign ALUOp_o     = ctrl_q.alu_op;
  assign illegal_o   = ctrl_q.illegal;
  assign stall_o     = hazard;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Scoreboard bench for pipelined_decoder: a transaction-level model predicts
// handshake/stall per cycle and queues expected decoded words; a monitor
// compares the DUT output register against the queue head.
module tb_pipelined_decoder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, out_instr, out_pc;
  logic [4:0]  rs1, rs2, rd;
  logic        alu_src, reg_write, branch, jump, mem_read, mem_write, mem_to_reg;
  logic [1:0]  alu_op;
  logic        illegal, stall;

  // Second instance with jumps disabled, driven separately
  logic        nj_in_valid, nj_in_ready, nj_out_valid, nj_stall, nj_illegal;
  logic [31:0] nj_instr, nj_out_instr, nj_out_pc;
  logic [4:0]  nj_rs1, nj_rs2, nj_rd;
  logic        nj_src, nj_rw, nj_br, nj_j, nj_mr, nj_mw, nj_mtr;
  logic [1:0]  nj_aluop;

  pipelined_decoder u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_instr_o(out_instr), .out_pc_o(out_pc),
    .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .ALUSrc_o(alu_src), .RegWrite_o(reg_write),
    .Branch_o(branch), .Jump_o(jump), .MemRead_o(mem_read), .MemWrite_o(mem_write),
    .MemtoReg_o(mem_to_reg), .ALUOp_o(alu_op), .illegal_o(illegal), .stall_o(stall)
  );

  pipelined_decoder #(.ENABLE_JUMP(1'b0)) u_dut_nj (
    .clk_i(clk), .rst_i(rst), .in_valid_i(nj_in_valid), .in_ready_o(nj_in_ready),
    .instr_i(nj_instr), .pc_i(32'h0), .flush_i(1'b0), .out_valid_o(nj_out_valid),
    .out_ready_i(1'b1), .out_instr_o(nj_out_instr), .out_pc_o(nj_out_pc),
    .rs1_o(nj_rs1), .rs2_o(nj_rs2), .rd_o(nj_rd), .ALUSrc_o(nj_src), .RegWrite_o(nj_rw),
    .Branch_o(nj_br), .Jump_o(nj_j), .MemRead_o(nj_mr), .MemWrite_o(nj_mw),
    .MemtoReg_o(nj_mtr), .ALUOp_o(nj_aluop), .illegal_o(nj_illegal), .stall_o(nj_stall)
  );

  // ctrl vector: {alu_src, reg_write, branch, jump, mem_read, mem_write, mem_to_reg, alu_op, illegal}
  logic [9:0] act_ctrl, nj_ctrl;
  assign act_ctrl = {alu_src, reg_write, branch, jump, mem_read, mem_write, mem_to_reg, alu_op,
                     illegal};
  assign nj_ctrl  = {nj_src, nj_rw, nj_br, nj_j, nj_mr, nj_mw, nj_mtr, nj_aluop, nj_illegal};

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [9:0]  ctrl;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  bit   m_valid = 1'b0;
  exp_t m_held;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode, straight from the opcode table
  function automatic logic [9:0] ref_ctrl(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    case (op)
      7'b0110011: return 10'b0100000_10_0;  // R
      7'b0010011: return 10'b1100000_11_0;  // I-ALU
      7'b0000011: return 10'b1100101_00_0;  // lw
      7'b0100011: return 10'b1000010_00_0;  // sw
      7'b1100011: return 10'b0010000_01_0;  // branch
      7'b1101111: return 10'b0101000_00_0;  // jal
      7'b1100111: return 10'b1101000_00_0;  // jalr
      7'b0110111: return 10'b1100000_00_0;  // lui
      7'b0010111: return 10'b1100000_00_0;  // auipc
      default:    return 10'b0000000_00_1;
    endcase
  endfunction

  function automatic bit uses1(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction

  function automatic bit uses2(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  // One clock of stimulus. Inputs change at posedge+1; model checks and
  // updates at posedge+6, ahead of the edge that ends the cycle.
  task automatic cycle(input bit r, input bit iv, input logic [31:0] w, input logic [31:0] p,
                       input bit fl, input bit ordy);
    bit   hz, rdy;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; in_valid = iv; instr = w; pc = p; flush = fl; out_ready = ordy;
    #5;
    hz  = m_valid && m_held.ctrl[5] && (m_held.instr[11:7] != 5'd0) && iv &&
          ((uses1(w) && w[19:15] == m_held.instr[11:7]) ||
           (uses2(w) && w[24:20] == m_held.instr[11:7]));
    rdy = !fl && !hz && (!m_valid || ordy);
    check("in_ready", in_ready, rdy);
    check("stall", stall, hz);
    if (r) begin
      m_valid = 1'b0;
      q.delete();
    end else if (fl) begin
      if (m_valid) void'(q.pop_front());
      m_valid = 1'b0;
    end else if (iv && rdy) begin
      e.instr = w; e.pc = p; e.ctrl = ref_ctrl(w);
      q.push_back(e);
      m_held  = e;
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: output register must match queue head while valid, pops on handshake
  always @(posedge clk) begin
    #4;
    if (mon_en) begin
      check("out_valid", out_valid, q.size() != 0);
      if (out_valid && q.size() != 0) begin
        check("out_instr", out_instr, q[0].instr);
        check("out_pc", out_pc, q[0].pc);
        check("ctrl", act_ctrl, q[0].ctrl);
        check("fields", {rs1, rs2, rd}, {q[0].instr[19:15], q[0].instr[24:20], q[0].instr[11:7]});
        if (out_ready && !flush && !rst) void'(q.pop_front());
      end else if (!out_valid) begin
        check("idle_ctrl", act_ctrl, 10'd0);
      end
    end
  end

  localparam logic [31:0] IAdd   = 32'h002081B3;
  localparam logic [31:0] IAddi  = 32'h00700293;
  localparam logic [31:0] ILw6   = 32'h0000A303;
  localparam logic [31:0] IAdd7  = 32'h002303B3;
  localparam logic [31:0] ILw0   = 32'h0000A003;
  localparam logic [31:0] IAdd70 = 32'h002003B3;
  localparam logic [31:0] IBeq   = 32'h00208063;
  localparam logic [31:0] IJal   = 32'h0000006F;

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  initial begin
    logic [31:0] w;
    rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0; out_ready = 1'b0;
    nj_in_valid = 1'b0; nj_instr = '0;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;

    // Reset held with a valid input
    cycle(1, 1, IAdd, 32'h4, 0, 1);
    cycle(1, 1, IAdd, 32'h4, 0, 1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ctrl", act_ctrl, 10'd0);
    check("rst_instr", {out_instr, out_pc}, 64'd0);

    // Streaming
    cycle(0, 1, IAdd, 32'h100, 0, 1);
    cycle(0, 1, IAddi, 32'h104, 0, 1);
    check("add_ctrl", {reg_write, alu_op, alu_src, rd}, {1'b1, 2'b10, 1'b0, 5'd3});
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    check("addi_ctrl", {alu_src, alu_op, rd}, {1'b1, 2'b11, 5'd5});

    // Load-use: one bubble, dependent add two cycles after the lw
    cycle(0, 1, ILw6, 32'h200, 0, 1);
    cycle(0, 1, IAdd7, 32'h204, 0, 1);
    check("lu_stall", stall, 1'b1);
    check("lu_lw_out", {out_valid, out_instr}, {1'b1, ILw6});
    cycle(0, 1, IAdd7, 32'h204, 0, 1);
    check("lu_bubble", out_valid, 1'b0);
    check("lu_nostall2", stall, 1'b0);
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    check("lu_add_out", {out_valid, out_instr}, {1'b1, IAdd7});

    // Load to x0 never stalls
    cycle(0, 1, ILw0, 32'h300, 0, 1);
    cycle(0, 1, IAdd70, 32'h304, 0, 1);
    check("x0_nostall", {stall, in_ready}, 2'b01);

    // Backpressure on a branch
    cycle(0, 1, IBeq, 32'h400, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, IAddi, 32'h404, 0, 0);
      check("bp_hold", {out_instr, branch, alu_op, in_ready}, {IBeq, 1'b1, 2'b01, 1'b0});
    end
    cycle(0, 1, IAddi, 32'h404, 0, 1);
    cycle(0, 0, 32'h0, 32'h0, 0, 1);

    // Flush while a lw is held and the next word is valid
    cycle(0, 1, ILw6, 32'h500, 0, 0);
    cycle(0, 1, IAdd, 32'h504, 1, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    check("flush_kill", out_valid, 1'b0);

    // jal with jumps disabled (second instance) and enabled
    nj_in_valid = 1'b1; nj_instr = IJal;
    cycle(0, 1, IJal, 32'h600, 0, 1);
    nj_in_valid = 1'b0;
    check("nj_jal", {nj_out_valid, nj_ctrl}, {1'b1, 10'b0000000_00_1});
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    check("jal_ctrl", {jump, reg_write, illegal}, 3'b110);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      w = $urandom;
      w[6:0]   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
      w[11:7]  = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, w, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    // Drain: nothing lost
    repeat (3) cycle(0, 0, 32'h0, 32'h0, 0, 1);
    check("drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
